// File: rtl/spi_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_seq_pkg
// Brief    : Shared types and constants for the spi_24b sequencer: state
//            encoding, frame width and the boot configuration word list.
// Revision : 1.0 - initial release
// ============================================================================
package spi_seq_pkg;

    localparam int SPI_W = 24;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        LOAD = 3'd1,
        IDLE = 3'd2,
        XFER = 3'd3,
        GAP  = 3'd4
    } seq_state_t;

    // Boot words are played in index order, word 0 first.
    localparam int INIT_LEN = 2;
    localparam logic [SPI_W-1:0] INIT_ROM [INIT_LEN] = '{24'hAA00AA, 24'h0055AA};

endpackage
`default_nettype wire

// File: rtl/spi_seq_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : spi_seq_rr_arb
// Brief    : Round-robin arbiter. Grant is combinational from the current
//            pointer; the pointer moves to grant+1 (mod NREQ) on advance.
// Revision : 1.0 - initial release
// ============================================================================
module spi_seq_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic            grant_valid,
    output logic [IDXW-1:0] grant_idx
);

    logic [IDXW-1:0] ptr_q;
    logic [IDXW-1:0] ptr_d;

    function automatic logic [IDXW-1:0] wrap(input int v);
        return IDXW'(v % NREQ);
    endfunction

    // Search from the pointer upward; walking offsets downward lets the
    // nearest active requester overwrite any farther one.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            if (req[wrap(int'(ptr_q) + off)]) begin
                grant_valid = 1'b1;
                grant_idx   = wrap(int'(ptr_q) + off);
            end
        end
    end

    // Next pointer: the requester after the one just granted.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = wrap(int'(grant_idx) + 1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_24b_seq.sv
`default_nettype none
// ============================================================================
// Module   : spi_24b_seq
// Brief    : Sequencer in front of the spi_24b serialiser. Plays the boot
//            word list after reset, then serves NREQ requesters round-robin,
//            with a fixed idle gap between frames and a per-frame timeout.
//            Macro SPI_SEQ_BOOT_EN compiles in the boot list; without it
//            reset lands directly in IDLE with init_done already high.
// Revision : 1.0 - initial release
// ============================================================================
module spi_24b_seq
    import spi_seq_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SPI_W-1:0] req_data,
    output logic [NREQ-1:0]       req_ack,
    output logic                  spi_en,
    output logic [SPI_W-1:0]      spi_data_out,
    input  logic                  spi_done,
    output logic                  busy,
    output logic                  init_done,
    output logic                  err
);

    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef SPI_SEQ_BOOT_EN
    localparam int         ROM_W         = $clog2(INIT_LEN + 1);
    localparam seq_state_t RST_STATE     = BOOT;
    localparam logic       RST_INIT_DONE = 1'b0;
    logic [ROM_W-1:0] rom_idx_q;
    logic [ROM_W-1:0] rom_idx_d;
`else
    localparam seq_state_t RST_STATE     = IDLE;
    localparam logic       RST_INIT_DONE = 1'b1;
`endif

    seq_state_t        state_q, state_d;
    logic              en_q, en_d;
    logic [SPI_W-1:0]  data_q, data_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [IDXW-1:0]   grant_q, grant_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              init_done_q, init_done_d;

    logic              grant_valid;
    logic [IDXW-1:0]   grant_idx;
    logic              advance;
    logic [SPI_W-1:0]  req_words [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
        assign req_words[gi] = req_data[gi*SPI_W +: SPI_W];
    end

    spi_seq_rr_arb #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .advance     (advance),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next-state and output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        data_d      = data_q;
        ack_d       = '0;
        grant_d     = grant_q;
        gap_d       = gap_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        init_done_d = init_done_q;
        advance     = 1'b0;
`ifdef SPI_SEQ_BOOT_EN
        rom_idx_d   = rom_idx_q;
`endif
        case (state_q)
            BOOT: begin
`ifdef SPI_SEQ_BOOT_EN
                if (rom_idx_q == ROM_W'(INIT_LEN)) begin
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    for (int i = 0; i < INIT_LEN; i++) begin
                        if (rom_idx_q == ROM_W'(i)) begin
                            data_d = INIT_ROM[i];
                        end
                    end
                    rom_idx_d = rom_idx_q + 1'b1;
                    en_d      = 1'b1;
                    tmo_d     = '0;
                    state_d   = LOAD;
                end
`else
                state_d = IDLE;
`endif
            end
            IDLE: begin
                if (grant_valid) begin
                    data_d  = req_words[grant_idx];
                    grant_d = grant_idx;
                    advance = 1'b1;
                    en_d    = 1'b1;
                    tmo_d   = '0;
                    state_d = XFER;
                end
            end
            LOAD, XFER: begin
                // A done arriving on the last allowed cycle still counts as
                // a normal completion.
                if (spi_done || (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
                    en_d    = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                    if (state_q == XFER) begin
                        ack_d[grant_q] = 1'b1;
                    end
                    if (!spi_done) begin
                        err_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = init_done_q ? IDLE : BOOT;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            en_q        <= 1'b0;
            data_q      <= '0;
            ack_q       <= '0;
            grant_q     <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            init_done_q <= RST_INIT_DONE;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            grant_q     <= grant_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef SPI_SEQ_BOOT_EN
    // Boot list read index; restarts from word 0 on every reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_idx_q <= '0;
        end else begin
            rom_idx_q <= rom_idx_d;
        end
    end
`endif

    assign spi_en       = en_q;
    assign spi_data_out = data_q;
    assign req_ack      = ack_q;
    assign busy         = (state_q != IDLE);
    assign init_done    = init_done_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_24b_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_24b_seq
// Brief    : Self-checking bench for spi_24b_seq with a serialiser model,
//            auto-releasing requesters and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_24b_seq;

    localparam int NREQ = 4;
    localparam int W    = 24;
    localparam int GAP  = 10;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ack;
    logic              spi_en;
    logic [W-1:0]      spi_data_out;
    logic              spi_done;
    logic              busy;
    logic              init_done;
    logic              err;

    spi_24b_seq #(
        .NREQ           (NREQ),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .spi_en       (spi_en),
        .spi_data_out (spi_data_out),
        .spi_done     (spi_done),
        .busy         (busy),
        .init_done    (init_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int done_cyc;
    int hi_run;
    int low_run;
    int en_cnt;
    int frame_len;
    int stab_viol;
    int ptr_model;
    bit prev_en;
    bit seen_fall;
    bit hold_done;
    bit rearm;
    bit exp_err;
    logic [W-1:0] last_data;
    logic [W-1:0] cur_word [NREQ];

    logic [W-1:0]    fr_data  [$];
    int              fr_len   [$];
    int              len_plan [$];
    int              low_len  [$];
    logic [NREQ-1:0] ack_seen [$];
    int              ack_lat  [$];

    task automatic set_word(input int i, input logic [W-1:0] w);
        req_data[i*W +: W] = w;
        cur_word[i]        = w;
    endtask

    task automatic clear_q();
        fr_data.delete(); fr_len.delete(); len_plan.delete();
        low_len.delete(); ack_seen.delete(); ack_lat.delete();
        stab_viol = 0;
    endtask

    // One clock: observe outputs, release/re-arm acked requesters, then
    // let the serialiser model decide spi_done for the coming edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (spi_en && !prev_en) begin
            fr_data.push_back(spi_data_out);
            if (seen_fall) low_len.push_back(low_run);
            hi_run    = 0;
            last_data = spi_data_out;
            frame_len = $urandom_range(2, 10);
            len_plan.push_back(frame_len);
            en_cnt    = 0;
        end
        if (spi_en) begin
            hi_run++;
            if (spi_data_out !== last_data) stab_viol++;
        end else begin
            if (prev_en) begin
                fr_len.push_back(hi_run);
                seen_fall = 1'b1;
                low_run   = 0;
            end
            low_run++;
        end
        prev_en = spi_en;
        if (req_ack !== '0) begin
            ack_seen.push_back(req_ack);
            ack_lat.push_back(cyc - done_cyc);
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i]) begin
                    if (rearm) set_word(i, W'($urandom));
                    else       req[i] = 1'b0;
                end
            end
        end
        spi_done = 1'b0;
        if (spi_en) begin
            en_cnt++;
            if (!hold_done && en_cnt == frame_len) begin
                spi_done = 1'b1;
                done_cyc = cyc;
            end
        end
    endtask

    task automatic wait_ack(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && ack_seen.size() == 0; i++) tick();
        if (ack_seen.size() > 0) ok = 1'b1;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !(busy === 1'b0 && spi_en === 1'b0); i++) tick();
        if (busy === 1'b0 && spi_en === 1'b0) ok = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_data = '0; spi_done = 1'b0;
        repeat (3) tick();
        checks++; if (spi_en !== 1'b0) begin errors++; $display("FAIL rst_spi_en got %b want 0", spi_en); end
        checks++; if (spi_data_out !== '0) begin errors++; $display("FAIL rst_data got %h want 000000", spi_data_out); end
        checks++; if (req_ack !== '0) begin errors++; $display("FAIL rst_ack got %b want 0000", req_ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
`ifdef SPI_SEQ_BOOT_EN
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
`else
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
`endif
    endtask

    task automatic test_boot();
        clear_q();
        rst_n = 1'b1;
`ifdef SPI_SEQ_BOOT_EN
        for (int i = 0; i < 200 && init_done !== 1'b1; i++) tick();
        checks++; if (fr_data.size() != 2) begin errors++; $display("FAIL boot_count got %0d want 2", fr_data.size()); end
        checks++; if (fr_data[0] !== 24'hAA00AA) begin errors++; $display("FAIL boot_word0 got %h want aa00aa", fr_data[0]); end
        checks++; if (fr_data[1] !== 24'h0055AA) begin errors++; $display("FAIL boot_word1 got %h want 0055aa", fr_data[1]); end
        checks++; if (low_len.size() != 1 || low_len[0] != GAP + 1) begin errors++; $display("FAIL boot_gap got %0d want %0d", low_len.size() > 0 ? low_len[0] : -1, GAP + 1); end
        checks++; if (ack_seen.size() != 0) begin errors++; $display("FAIL boot_no_ack got %0d want 0", ack_seen.size()); end
`else
        repeat (6) tick();
        checks++; if (fr_data.size() != 0) begin errors++; $display("FAIL noboot_frames got %0d want 0", fr_data.size()); end
`endif
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL boot_init_done got %b want 1", init_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boot_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        bit ok;
        wait_idle(200, ok);
        clear_q();
        set_word(2, 24'h123456);
        req = 4'b0100;
        tick();
        checks++; if (spi_en !== 1'b1) begin errors++; $display("FAIL single_latency got %b want 1", spi_en); end
        checks++; if (spi_data_out !== 24'h123456) begin errors++; $display("FAIL single_data got %h want 123456", spi_data_out); end
        // Disturb the requester after grant: the frame must not notice.
        req_data[2*W +: W] = 24'hFFFFFF;
        req[2] = 1'b0;
        wait_ack(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_ack_wait got none want ack"); end
        checks++; if (ack_seen[0] !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack_seen[0]); end
        checks++; if (ack_lat[0] != 1) begin errors++; $display("FAIL single_ack_lat got %0d want 1", ack_lat[0]); end
        checks++; if (fr_len[0] != len_plan[0]) begin errors++; $display("FAIL single_len got %0d want %0d", fr_len[0], len_plan[0]); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL single_stable got %0d want 0", stab_viol); end
        ptr_model = 3;
    endtask

    task automatic test_fairness();
        bit ok;
        int g;
        logic [W-1:0] exp_w;
        wait_idle(200, ok);
        clear_q();
        for (int i = 0; i < NREQ; i++) set_word(i, W'($urandom));
        rearm = 1'b1;
        req   = '1;
        for (int k = 0; k < 8; k++) begin
            g     = ptr_model;
            exp_w = cur_word[g];
            wait_ack(100, ok);
            checks++; if (!ok || ack_seen.pop_front() !== 4'(1 << g)) begin errors++; $display("FAIL fair_grant k=%0d want req %0d", k, g); end
            checks++; if (fr_data.pop_front() !== exp_w) begin errors++; $display("FAIL fair_data k=%0d want %h", k, exp_w); end
            if (low_len.size() > 0) begin
                int lo = low_len.pop_front();
                if (k > 0) begin
                    checks++; if (lo != GAP + 1) begin errors++; $display("FAIL fair_gap k=%0d got %0d want %0d", k, lo, GAP + 1); end
                end
            end
            ptr_model = (g + 1) % NREQ;
        end
        rearm = 1'b0;
        req   = '0;
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL fair_stable got %0d want 0", stab_viol); end
    endtask

    task automatic test_random();
        bit ok;
        logic [NREQ-1:0] m;
        int order [$];
        int g;
        for (int r = 0; r < 6; r++) begin
            wait_idle(200, ok);
            clear_q();
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) if (m[i]) set_word(i, W'($urandom));
            order.delete();
            for (int off = 0; off < NREQ; off++) if (m[(ptr_model + off) % NREQ]) order.push_back((ptr_model + off) % NREQ);
            req = m;
            foreach (order[k]) begin
                g = order[k];
                wait_ack(100, ok);
                checks++; if (!ok || ack_seen.pop_front() !== 4'(1 << g)) begin errors++; $display("FAIL rand_grant r=%0d k=%0d want req %0d", r, k, g); end
                checks++; if (fr_data.pop_front() !== cur_word[g]) begin errors++; $display("FAIL rand_data r=%0d k=%0d want %h", r, k, cur_word[g]); end
                checks++; if (ack_lat.pop_front() != 1) begin errors++; $display("FAIL rand_ack_lat r=%0d k=%0d want 1", r, k); end
                ptr_model = (g + 1) % NREQ;
            end
        end
    endtask

    task automatic test_withdraw();
        bit ok;
        wait_idle(200, ok);
        clear_q();
        set_word(1, W'($urandom));
        req = 4'b0010;
        wait_ack(100, ok);
        ptr_model = 2;
        set_word(3, W'($urandom));
        req[3] = 1'b1;
        repeat (3) tick();
        req[3] = 1'b0;
        repeat (25) tick();
        checks++; if (ack_seen.size() != 1) begin errors++; $display("FAIL withdraw_acks got %0d want 1", ack_seen.size()); end
        checks++; if (fr_data.size() != 1) begin errors++; $display("FAIL withdraw_frames got %0d want 1", fr_data.size()); end
    endtask

    task automatic test_stray_done();
        bit ok;
        wait_idle(200, ok);
        clear_q();
        spi_done = 1'b1;
        repeat (4) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stray_busy got %b want 0", busy); end
        checks++; if (fr_data.size() != 0 || ack_seen.size() != 0) begin errors++; $display("FAIL stray_activity got %0d frames want 0", fr_data.size()); end
        checks++; if (err !== exp_err) begin errors++; $display("FAIL stray_err got %b want %b", err, exp_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        int g;
        logic [W-1:0] w;
        wait_idle(200, ok);
        clear_q();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tmo_err_before got %b want 0", err); end
        g = $urandom_range(0, NREQ - 1);
        w = W'($urandom);
        set_word(g, w);
        hold_done = 1'b1;
        req = 4'(1 << g);
        wait_ack(100, ok);
        checks++; if (!ok || ack_seen[0] !== 4'(1 << g)) begin errors++; $display("FAIL tmo_ack got %b want %b", ack_seen[0], 4'(1 << g)); end
        checks++; if (fr_len[0] != TMO) begin errors++; $display("FAIL tmo_len got %0d want %0d", fr_len[0], TMO); end
        checks++; if (fr_data[0] !== w) begin errors++; $display("FAIL tmo_data got %h want %h", fr_data[0], w); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", err); end
        hold_done = 1'b0;
        exp_err   = 1'b1;
        ptr_model = (g + 1) % NREQ;
        wait_idle(100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        wait_idle(200, ok);
        clear_q();
        set_word(2, W'($urandom));
        hold_done = 1'b1;
        req = 4'b0100;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (spi_en !== 1'b0) begin errors++; $display("FAIL arst_spi_en got %b want 0", spi_en); end
        checks++; if (spi_data_out !== '0) begin errors++; $display("FAIL arst_data got %h want 000000", spi_data_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL arst_err got %b want 0", err); end
        hold_done = 1'b0;
        req = '0;
        repeat (2) tick();
        prev_en = 1'b0; seen_fall = 1'b0; en_cnt = 0; exp_err = 1'b0; ptr_model = 0;
        clear_q();
        rst_n = 1'b1;
`ifdef SPI_SEQ_BOOT_EN
        for (int i = 0; i < 200 && init_done !== 1'b1; i++) tick();
        checks++; if (fr_data.size() != 2 || fr_data[0] !== 24'hAA00AA) begin errors++; $display("FAIL arst_reboot got %h want aa00aa", fr_data[0]); end
`else
        tick();
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL arst_init_done got %b want 1", init_done); end
`endif
        // Pointer must be back at 0, so requester 1 wins over 3.
        clear_q();
        set_word(1, W'($urandom));
        set_word(3, W'($urandom));
        req = 4'b1010;
        wait_ack(100, ok);
        checks++; if (!ok || ack_seen[0] !== 4'b0010) begin errors++; $display("FAIL arst_ptr got %b want 0010", ack_seen[0]); end
        checks++; if (fr_data[0] !== cur_word[1]) begin errors++; $display("FAIL arst_data1 got %h want %h", fr_data[0], cur_word[1]); end
        req = '0;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; done_cyc = -100;
        hi_run = 0; low_run = 0; en_cnt = 0; frame_len = 5; stab_viol = 0;
        ptr_model = 0; prev_en = 1'b0; seen_fall = 1'b0;
        hold_done = 1'b0; rearm = 1'b0; exp_err = 1'b0; last_data = '0;
        for (int i = 0; i < NREQ; i++) cur_word[i] = '0;
        test_reset();
        test_boot();
        test_single();
        test_fairness();
        test_random();
        test_withdraw();
        test_stray_done();
        test_timeout();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
